reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Sits directly downstream of the reset synchronizer. Its `reset` input is driven by the synchronizer's synchronized, active-low reset output.
- Releases NUM_STAGES downstream reset domains one at a time, in index order.
- Before each release it waits a fixed delay, and it requires a per-stage ready acknowledge before moving to the next stage. A missing acknowledge is caught by a timeout.
- Provides a soft-reset request that restarts the whole sequence without an external reset.

Parameters:
- NUM_STAGES, 3: number of sequenced reset domains (>=1).
- STAGE_DELAY, 16: hold cycles before each stage release (>=1).
- ACK_TIMEOUT, 255: cycles allowed for stage_ack after a release; 0 disables the timeout.
- CNT_WIDTH, 8: internal counter width; must hold max(STAGE_DELAY, ACK_TIMEOUT).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset (from reset synchronizer)
- soft_reset_req  input  1  synchronous request to re-run the sequence
- stage_ack  input  NUM_STAGES  per-stage ready acknowledge (level, synchronous to clk)
- stage_reset_n  output  NUM_STAGES  per-stage active-low reset; bit i releases i-th
- seq_done  output  1  all stages released and acknowledged
- seq_error  output  1  acknowledge timeout occurred
- error_stage  output  max(1,clog2(NUM_STAGES))  index of the stage that timed out

Behaviour:
- Reset and sampling:
  - Reset asserted (low): asynchronously force stage_reset_n=0 (all bits), seq_done=0, seq_error=0, error_stage=0, state=HOLD, stage index=0, counter=0.
  - All outputs are registered. All inputs are sampled on the rising edge of clk.
- FSM states: HOLD, WAIT_ACK, DONE, ERROR.
- HOLD:
  - Counter increments every edge.
  - On the edge where counter==STAGE_DELAY-1: set stage_reset_n[idx]=1, clear counter, go to WAIT_ACK.
  - Result: stage 0 releases on the STAGE_DELAY-th edge after reset deassertion. Stage i+1 releases exactly STAGE_DELAY edges after the edge that accepted stage_ack[i].
- WAIT_ACK:
  - Only stage_ack[idx] is observed; other ack bits are ignored.
  - Ack high at an edge: idx==NUM_STAGES-1 -> DONE; otherwise idx+1, counter=0, HOLD.
  - Ack low: counter increments.
  - If ACK_TIMEOUT!=0 and counter==ACK_TIMEOUT-1 with ack low -> ERROR. That is, ERROR is entered ACK_TIMEOUT edges after the release edge.
  - Ack high on the timeout edge wins: it is accepted, not an error.
- DONE: seq_done=1. Stays until soft_reset_req or reset.
- ERROR:
  - On entry, all stage_reset_n bits return to 0, including already-released stages.
  - seq_error=1 and error_stage=idx.
  - Stays until soft_reset_req or reset.
- soft_reset_req:
  - Sampled high in any state: that edge forces stage_reset_n=0, seq_done=0, seq_error=0, error_stage=0, idx=0, counter=0, state=HOLD.
  - While held high, the block stays at HOLD with counter=0. The delay count starts on the first edge with the request low, so stage 0 releases STAGE_DELAY edges after the last high-sampled edge.
- Monotonic release: once released, stage_reset_n[i] stays 1 until soft reset, reset, or ERROR.
- Counter never wraps: it is cleared at every state transition. ACK_TIMEOUT=0 makes WAIT_ACK wait indefinitely.
- Reset mid-sequence: behaves exactly as the initial reset. No partial state survives.

Test Plan:
- NUM_STAGES=3, STAGE_DELAY=4, ACK_TIMEOUT=8, acks tied high:
  - stage_reset_n goes 001 at edge 4, 011 at edge 9, 111 at edge 14.
  - seq_done=1 after edge 15.
  - seq_error stays 0 throughout.
- Same parameters, stage_ack[1] never asserted:
  - stage_reset_n=011 from edge 9 to edge 16.
  - At edge 17: stage_reset_n=000, seq_error=1, error_stage=1.
  - seq_done stays 0.
- stage_ack[1] first high exactly at edge 17 (the timeout edge): ack accepted, no error, stage 2 releases at edge 21.
- From DONE, pulse soft_reset_req high for 3 edges:
  - stage_reset_n=000 and seq_done=0 from the first pulse edge.
  - Stage 0 releases 4 edges after the last high edge.
  - Full sequence repeats.
- Assert reset low asynchronously, mid-clock, while stage_reset_n=011: all outputs drop immediately without a clock edge; after release the sequence restarts from stage 0.
- Ack for a non-current stage (stage_ack=100 while waiting on stage 0): ignored; timeout still fires for stage 0 with error_stage=0.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Releases NUM_STAGES downstream reset domains one at a time, in index order.
// Each release is preceded by a fixed hold delay. The sequencer then waits for
// that stage's ready acknowledge before moving to the next stage. A missing
// acknowledge is caught by an optional timeout, which drops every stage back
// into reset. A soft-reset request restarts the whole sequence.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset (from the reset synchronizer)
//   soft_reset_req synchronous request to re-run the sequence
//   stage_ack      per-stage ready acknowledge (level, synchronous to clk)
//   stage_reset_n  per-stage active-low reset; bit i is released i-th
//   seq_done       all stages released and acknowledged
//   seq_error      acknowledge timeout occurred
//   error_stage    index of the stage that timed out
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HOLD     | counting STAGE_DELAY cycles before releasing stage idx
// WAIT_ACK | stage idx released, waiting for stage_ack[idx] or timeout
// DONE     | every stage released and acknowledged
// ERROR    | acknowledge timeout, all stages forced back into reset

module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 16,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 8,
  localparam int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  soft_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  seq_done,
  output logic                  seq_error,
  output logic [IDX_W-1:0]      error_stage
);

  typedef enum logic [1:0] {HOLD, WAIT_ACK, DONE, ERROR} state_t;

  localparam logic [CNT_WIDTH-1:0] DELAY_TC = CNT_WIDTH'(STAGE_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] ACK_TC   =
    CNT_WIDTH'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);
  localparam bit               TIMEOUT_EN   = (ACK_TIMEOUT != 0);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [CNT_WIDTH-1:0]    counter;
  logic [NUM_STAGES-1:0]   release_mask;
  logic                    ack_cur;

  assign release_mask = NUM_STAGES'(1) << idx;
  // Only the acknowledge of the stage currently being waited on matters.
  assign ack_cur      = stage_ack[idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= HOLD;
      idx           <= '0;
      counter       <= '0;
      stage_reset_n <= '0;
      seq_done      <= 1'b0;
      seq_error     <= 1'b0;
      error_stage   <= '0;
    end else if (soft_reset_req) begin
      // Held request parks the block in HOLD with the counter cleared, so the
      // delay starts counting on the first edge the request is seen low.
      state         <= HOLD;
      idx           <= '0;
      counter       <= '0;
      stage_reset_n <= '0;
      seq_done      <= 1'b0;
      seq_error     <= 1'b0;
      error_stage   <= '0;
    end else begin
      unique case (state)
        HOLD: begin
          if (counter == DELAY_TC) begin
            stage_reset_n <= stage_reset_n | release_mask;
            counter       <= '0;
            state         <= WAIT_ACK;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        WAIT_ACK: begin
          // Acknowledge takes priority over a timeout on the same edge.
          if (ack_cur) begin
            counter <= '0;
            if (idx == LAST_IDX) begin
              seq_done <= 1'b1;
              state    <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= HOLD;
            end
          end else if (TIMEOUT_EN && counter == ACK_TC) begin
            counter       <= '0;
            stage_reset_n <= '0;
            seq_error     <= 1'b1;
            error_stage   <= idx;
            state         <= ERROR;
          end else if (TIMEOUT_EN) begin
            // With the timeout disabled the counter is frozen so it never wraps.
            counter <= counter + 1'b1;
          end
        end
        DONE:  state <= DONE;
        ERROR: state <= ERROR;
        default: state <= HOLD;
      endcase
    end
  end

endmodule
